dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL be the number of cycles in REQ+RSP after which an access aborts with bus_err_o.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 wmem_en_i  input  1  SHALL request a store (from mem stage).
REQ-005 rmem_en_i  input  1  SHALL request a load; if wmem_en_i is also 1, the store wins.
REQ-006 mem_addr_i  input  32  SHALL be the byte address.
REQ-007 mem_data_i  input  32  SHALL be the store data, already zero-extended, in low bits.
REQ-008 funct3_i  input  3  SHALL be the access size code (byte, half, word, byte_u, half_u).
REQ-009 stall_o  output  1  SHALL hold the pipeline while an access is outstanding.
REQ-010 rdata_o  output  32  SHALL carry load data right-aligned, upper bits zero; the mem stage performs the extension.
REQ-011 misalign_o  output  1  SHALL be a one-cycle misaligned-access flag.
REQ-012 bus_err_o  output  1  SHALL be a one-cycle timeout flag.
REQ-013 bus_req_o, bus_we_o  output  1 each  SHALL be the bus request and write strobe.
REQ-014 bus_addr_o  output  32  SHALL be word-aligned (mem_addr_i with bits [1:0] forced to 0).
REQ-015 bus_be_o  output  4  SHALL be the byte enables.
REQ-016 bus_wdata_o  output  32  SHALL be the lane-replicated store data.
REQ-017 bus_gnt_i, bus_rvalid_i  input  1 each  SHALL be grant and read-response-valid.
REQ-018 bus_rdata_i  input  32  SHALL be the read word.

Function
REQ-019 FSM states SHALL be IDLE, REQ, RSP and DONE.
REQ-020 IDLE: if an aligned, valid access is present, stall_o SHALL be 1 combinationally and the next state SHALL be REQ; otherwise stall_o SHALL be 0.
REQ-021 REQ: bus_req_o=1, with addr/we/be/wdata held stable; on bus_gnt_i the next state SHALL be DONE for a store or RSP for a load.
REQ-022 RSP: bus_req_o=0; on bus_rvalid_i the steered data SHALL be registered into rdata_o and the next state SHALL be DONE. bus_rvalid_i is never sampled in the grant cycle.
REQ-023 DONE: stall_o=0 and rdata_o valid for exactly this cycle; the next state SHALL be IDLE unconditionally, so the same inputs never re-trigger.
REQ-024 Upstream SHALL hold inputs stable while stall_o=1; in REQ/RSP the block uses its registered copy of addr/funct3/data.
REQ-025 Byte enables: byte SHALL be 4'b0001<<addr[1:0]; half SHALL be 4'b0011<<{addr[1],1'b0}; word SHALL be 4'b1111.
REQ-026 Store data: byte SHALL be replicated x4; half SHALL be replicated x2; word SHALL pass unchanged.
REQ-027 Load steering: byte lanes SHALL be bus_rdata_i>>(8*addr[1:0]) masked to 8 bits; half SHALL be >>(16*addr[1]) masked to 16 bits; word SHALL pass unchanged.
REQ-028 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus request SHALL be issued, misalign_o SHALL be 1 for one cycle, stall_o=0, and the FSM SHALL stay in IDLE.
REQ-029 An invalid funct3 with an enable set SHALL be treated as a no-op: no request, no stall, no flag.
REQ-030 A timeout counter SHALL clear on entering REQ and increment in REQ/RSP; on reaching TIMEOUT-1 it SHALL drop bus_req_o, go to DONE, assert bus_err_o for that cycle and force rdata_o=0.
REQ-031 bus_rvalid_i arriving in IDLE or DONE SHALL be ignored.
REQ-032 rdata_o SHALL hold its last value outside DONE.

Reset
REQ-033 On rst (asynchronous, active-high): state=IDLE, bus_req_o=0, bus_we_o=0, bus_be_o=0, bus_addr_o=0, bus_wdata_o=0, rdata_o=0, misalign_o=0, bus_err_o=0, counter=0, and stall_o=0 unless a new access is presented after release.
REQ-034 Reset asserted mid-access SHALL abandon the access with no completion flag.

Structure
REQ-035 State encodings and the default TIMEOUT SHALL live in the shared header alongside the existing funct3 size codes and width macros.
REQ-036 Combinational lane logic (be, wdata replication, rdata steering) SHALL be one sub-module, dmem_lane; the FSM, registers and counter SHALL live in dmem_ctrl.

Verification
REQ-037 SB addr 0x1003, data 0x000000A5, gnt next cycle -> be=1000, wdata=0xA5A5A5A5, addr=0x1000, stall high 2 cycles, we=1.
REQ-038 LH addr 0x2002, rdata_i=0xBEEF1234 returned 2 cycles after gnt -> rdata_o=0x0000BEEF in DONE only, stall drops in DONE.
REQ-039 LW addr 0x3001 -> misalign_o=1 for one cycle, bus_req_o never asserted, stall_o=0.
REQ-040 LW, gnt given but rvalid never arrives, TIMEOUT=16 -> bus_err_o pulses at cycle 16 after the REQ entry, rdata_o=0, FSM returns to IDLE.
REQ-041 rst pulsed while in RSP, then late rvalid -> outputs reset, rvalid ignored, no DONE cycle.
REQ-042 Back-to-back SW then LB at 0x0 -> second access enters REQ in the cycle after DONE, with no duplicate store.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: widths, funct3 size
// codes, FSM state encodings, default timeout and small decode helpers.
package dmem_ctrl_pkg;

  localparam int XLEN        = 32;
  localparam int TIMEOUT_DEF = 16;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_RSP  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // funct3 access size codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size field is funct3[1:0]; the unsigned bit does not matter here since
  // load data is always returned zero-extended.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic f3_valid(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane logic: byte enables, store data replication and load data
// steering (right-aligned, zero-filled). Purely combinational.
module dmem_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  // Decode lanes from access size and the low address bits
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (rdata_i >> {off_i, 3'b000}) & 32'h0000_00FF;
      end
      SZ_H: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (rdata_i >> {off_i[1], 4'b0000}) & 32'h0000_FFFF;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns a mem-stage load/store into a single bus
// transaction (REQ -> optional RSP -> DONE), stalling the pipeline while it
// is outstanding, flagging misaligned accesses and aborting on timeout.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wmem_en_i,
  input  logic            rmem_en_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic [2:0]      funct3_i,
  output logic            stall_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o,
  output logic            bus_err_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_gnt_i,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              err_q, err_d;

  logic              access;
  logic              mis;
  logic              tmo;
  logic [1:0]        lane_size;
  logic [1:0]        lane_off;
  logic [3:0]        lane_be;
  logic [XLEN-1:0]   lane_wdata;
  logic [XLEN-1:0]   lane_rdata;

  assign access = (wmem_en_i || rmem_en_i) && f3_valid(funct3_i);
  assign mis    = misaligned(funct3_i[1:0], mem_addr_i[1:0]);
  assign tmo    = (cnt_q == CW'(TIMEOUT - 1));

  // In IDLE the lanes decode the live request; afterwards the captured copy
  // steers the read response.
  assign lane_size = (state_q == ST_IDLE) ? funct3_i[1:0]    : size_q;
  assign lane_off  = (state_q == ST_IDLE) ? mem_addr_i[1:0]  : addr_q[1:0];

  dmem_lane u_lane (
    .size_i  (lane_size),
    .off_i   (lane_off),
    .wdata_i (mem_data_i),
    .rdata_i (bus_rdata_i),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  // Next-state, capture and handshake logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    err_d      = 1'b0;
    stall_o    = 1'b0;
    bus_req_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (mis) begin
            misalign_d = 1'b1;
          end else begin
            stall_o = 1'b1;
            state_d = ST_REQ;
            cnt_d   = '0;
            addr_d  = mem_addr_i;
            size_d  = funct3_i[1:0];
            we_d    = wmem_en_i;
            be_d    = lane_be;
            wdata_d = lane_wdata;
          end
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (tmo) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          bus_req_o = 1'b1;
          if (bus_gnt_i) state_d = we_q ? ST_DONE : ST_RSP;
        end
      end
      ST_RSP: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (bus_rvalid_i) begin
          state_d = ST_DONE;
          rdata_d = lane_rdata;
        end else if (tmo) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      err_q      <= err_d;
    end
  end

  assign bus_addr_o  = {addr_q[XLEN-1:2], 2'b00};
  assign bus_we_o    = we_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed accesses push their expected bus
// transaction / completion / misalign events; a negedge monitor pops and
// compares whenever the DUT presents one.
module tb_dmem_ctrl;

  localparam int EV_BUS  = 0;
  localparam int EV_MIS  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        wmem_en, rmem_en;
  logic [31:0] mem_addr, mem_data;
  logic [2:0]  funct3;
  logic        stall_o, misalign_o, bus_err_o, bus_req_o, bus_we_o;
  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  dmem_ctrl #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .wmem_en_i    (wmem_en),
    .rmem_en_i    (rmem_en),
    .mem_addr_i   (mem_addr),
    .mem_data_i   (mem_data),
    .funct3_i     (funct3),
    .stall_o      (stall_o),
    .rdata_o      (rdata_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_be_o     (bus_be_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt),
    .bus_rvalid_i (bus_rvalid),
    .bus_rdata_i  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic [31:0] w, input logic we);
    exp_t e;
    e.kind = EV_BUS; e.addr = a; e.be = be; e.wdata = w; e.we = we;
    e.rdata = '0; e.err = 1'b0; e.stalls = 0;
    q.push_back(e);
  endtask

  task automatic push_done(input logic [31:0] rd, input logic err, input int stalls);
    exp_t e;
    e.kind = EV_DONE; e.addr = '0; e.be = '0; e.wdata = '0; e.we = 1'b0;
    e.rdata = rd; e.err = err; e.stalls = stalls;
    q.push_back(e);
  endtask

  task automatic push_mis();
    exp_t e;
    e.kind = EV_MIS; e.addr = '0; e.be = '0; e.wdata = '0; e.we = 1'b0;
    e.rdata = '0; e.err = 1'b0; e.stalls = 0;
    q.push_back(e);
  endtask

  task automatic on_event(input int kind, input int stalls);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got event kind %0d, required none", kind);
      return;
    end
    e = q.pop_front();
    chk("event_kind", 32'(kind), 32'(e.kind));
    if (kind != e.kind) return;
    case (kind)
      EV_BUS: begin
        $display("[TB] bus   addr=%08h be=%b we=%b wdata=%08h", bus_addr_o, bus_be_o, bus_we_o, bus_wdata_o);
        chk("bus_addr", bus_addr_o, e.addr);
        chk("bus_be", 32'(bus_be_o), 32'(e.be));
        chk("bus_we", 32'(bus_we_o), 32'(e.we));
        chk("bus_wdata", bus_wdata_o, e.wdata);
      end
      EV_DONE: begin
        $display("[TB] done  rdata=%08h err=%b stalls=%0d", rdata_o, bus_err_o, stalls);
        chk("done_rdata", rdata_o, e.rdata);
        chk("done_err", 32'(bus_err_o), 32'(e.err));
        chk("done_stalls", 32'(stalls), 32'(e.stalls));
      end
      default: $display("[TB] misalign flagged");
    endcase
  endtask

  // Monitor: sample away from the active edge
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else begin
        if (bus_req_o && bus_gnt) on_event(EV_BUS, 0);
        if (misalign_o) on_event(EV_MIS, 0);
        if (stall_o) stall_cnt++;
        else if (stall_cnt > 0) begin
          on_event(EV_DONE, stall_cnt);
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic idle_inputs();
    wmem_en = 1'b0; rmem_en = 1'b0; mem_addr = '0; mem_data = '0; funct3 = 3'b000;
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input int gd, input int rvd, input logic [31:0] rword,
                       input logic exp_bus, input int rst_at);
    int n;
    @(posedge clk); #1;
    wmem_en = we; rmem_en = re; mem_addr = a; mem_data = d; funct3 = f;
    @(negedge clk);
    chk("idle_stall", 32'(stall_o), 32'(exp_bus));
    if (!exp_bus) return;
    @(posedge clk); #1;
    n = 0;
    while (!bus_req_o && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_entry_delay", 32'(n), 32'd0);
    repeat (gd) begin @(posedge clk); #1; end
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    if (rst_at >= 0) begin
      repeat (rst_at) begin @(posedge clk); #1; end
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_req", 32'(bus_req_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    if (re && !we && rvd > 0) begin
      repeat (rvd - 1) begin @(posedge clk); #1; end
      bus_rdata = rword; bus_rvalid = 1'b1;
      @(posedge clk); #1;
      bus_rvalid = 1'b0;
    end
    n = 0;
    while (stall_o && n < 40) begin @(posedge clk); #1; n++; end
    if (stall_o) begin
      tests++;
      fails++;
      $display("FAIL done_wait: stall_o=1 after 40 cycles, required 0");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 32'(stall_o), 32'd0);
    chk("reset_req", 32'(bus_req_o), 32'd0);
    chk("reset_we", 32'(bus_we_o), 32'd0);
    chk("reset_be", 32'(bus_be_o), 32'd0);
    chk("reset_addr", bus_addr_o, 32'd0);
    chk("reset_wdata", bus_wdata_o, 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);
    chk("reset_flags", {30'd0, misalign_o, bus_err_o}, 32'd0);

    // SB 0x1003, grant in first REQ cycle
    push_bus(32'h1000, 4'b1000, 32'hA5A5_A5A5, 1'b1);
    push_done(32'h0, 1'b0, 2);
    drive(1'b1, 1'b0, 32'h1003, 32'h0000_00A5, 3'b000, 0, 0, 32'h0, 1'b1, -1);
    @(posedge clk); #1 idle_inputs();

    // LH 0x2002, response two cycles after grant
    push_bus(32'h2000, 4'b1100, 32'h0, 1'b0);
    push_done(32'h0000_BEEF, 1'b0, 4);
    drive(1'b0, 1'b1, 32'h2002, 32'h0, 3'b001, 0, 2, 32'hBEEF_1234, 1'b1, -1);
    @(posedge clk); #1 idle_inputs();

    // LW 0x3001 misaligned
    push_mis();
    drive(1'b0, 1'b1, 32'h3001, 32'h0, 3'b010, 0, 0, 32'h0, 1'b0, -1);
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    chk("mis_req", 32'(bus_req_o), 32'd0);
    chk("mis_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    chk("mis_one_cycle", 32'(misalign_o), 32'd0);

    // LW 0x4000 granted, no response: timeout
    push_bus(32'h4000, 4'b1111, 32'h0, 1'b0);
    push_done(32'h0, 1'b1, 17);
    drive(1'b0, 1'b1, 32'h4000, 32'h0, 3'b010, 0, -1, 32'h0, 1'b1, -1);
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    chk("tmo_err_one_cycle", 32'(bus_err_o), 32'd0);

    // LBU 0x5001, lane 1
    push_bus(32'h5000, 4'b0010, 32'h0, 1'b0);
    push_done(32'h0000_0033, 1'b0, 3);
    drive(1'b0, 1'b1, 32'h5001, 32'h0, 3'b100, 0, 1, 32'h1122_3344, 1'b1, -1);
    @(posedge clk); #1 idle_inputs();

    // SH 0x6002 with grant delayed two cycles
    push_bus(32'h6000, 4'b1100, 32'hBEEF_BEEF, 1'b1);
    push_done(32'h0000_0033, 1'b0, 4);
    drive(1'b1, 1'b0, 32'h6002, 32'h0000_BEEF, 3'b001, 2, 0, 32'h0, 1'b1, -1);
    @(posedge clk); #1 idle_inputs();

    // Back-to-back SW then LB at 0x0
    push_bus(32'h0, 4'b1111, 32'hCAFE_F00D, 1'b1);
    push_done(32'h0000_0033, 1'b0, 2);
    push_bus(32'h0, 4'b0001, 32'h0, 1'b0);
    push_done(32'h0000_0080, 1'b0, 3);
    drive(1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 3'b010, 0, 0, 32'h0, 1'b1, -1);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 3'b000, 0, 1, 32'h1234_5680, 1'b1, -1);
    @(posedge clk); #1 idle_inputs();

    // Invalid funct3 is a no-op
    drive(1'b1, 1'b0, 32'h8000, 32'h55, 3'b011, 0, 0, 32'h0, 1'b0, -1);
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    chk("noop_req", 32'(bus_req_o), 32'd0);
    chk("noop_flags", {30'd0, misalign_o, bus_err_o}, 32'd0);

    // Reset while in RSP, then a late response
    push_bus(32'h7000, 4'b1111, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h7000, 32'h0, 3'b010, 0, -1, 32'h0, 1'b1, 3);
    bus_rdata = 32'hDEAD_BEEF; bus_rvalid = 1'b1;
    @(posedge clk); #1 bus_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_stall", 32'(stall_o), 32'd0);
      chk("post_rst_rdata", rdata_o, 32'd0);
      chk("post_rst_addr", bus_addr_o, 32'd0);
      chk("post_rst_flags", {29'd0, bus_req_o, misalign_o, bus_err_o}, 32'd0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
